// File: rtl/rxd_ctrl.sv
// IrDA receive controller: synchronizes the decoded line, times start/data/stop
// sampling, strobes an external shift register and validates/buffers each byte.
module rxd_ctrl #(
    parameter int unsigned BIT_CYCLES  = 16,
    parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic       sdata,
    output logic       rshift,
    output logic       shift_clr,
    input  logic [9:0] data_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned BAUD_W = $clog2(BIT_CYCLES);
    localparam int unsigned BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST  = BAUD_W'(HALF_CYCLES - 1);
    localparam logic [BIT_W-1:0]  FRAME_BITS = BIT_W'(10);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        CHECK
    } state_e;

    state_e              state_q;
    logic                sync1_q;
    logic                sdata_q;
    logic                prev_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [BIT_W-1:0]    bit_q;
    logic                rshift_q;
    logic                shift_clr_q;
    logic [7:0]          rx_data_q;
    logic                rx_valid_q;
    logic                frame_err_q;
    logic                overrun_q;
    logic                frame_ok;

    // Start bit must read low and stop bit high once all ten bits are in.
    assign frame_ok = ~data_in[0] & data_in[9];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sdata_q     <= 1'b1;
            prev_q      <= 1'b1;
            baud_q      <= '0;
            bit_q       <= '0;
            rshift_q    <= 1'b0;
            shift_clr_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= serial_in;
            sdata_q     <= sync1_q;
            prev_q      <= sdata_q;
            rshift_q    <= 1'b0;
            shift_clr_q <= 1'b0;
            frame_err_q <= 1'b0;

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!sdata_q && prev_q) begin
                        state_q     <= START;
                        baud_q      <= '0;
                        bit_q       <= '0;
                        shift_clr_q <= 1'b1;
                    end
                end
                START: begin
                    if (baud_q == HALF_LAST) begin
                        baud_q <= '0;
                        if (!sdata_q) begin
                            rshift_q <= 1'b1;
                            bit_q    <= BIT_W'(1);
                            state_q  <= SHIFT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                SHIFT: begin
                    // Leave only once the tenth strobe has been seen by the shift register.
                    if (bit_q == FRAME_BITS) begin
                        state_q <= CHECK;
                        baud_q  <= '0;
                    end else if (baud_q == BAUD_LAST) begin
                        rshift_q <= 1'b1;
                        bit_q    <= bit_q + BIT_W'(1);
                        baud_q   <= '0;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    bit_q   <= '0;
                    if (frame_ok) begin
                        rx_data_q  <= data_in[8:1];
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !rx_ready) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdata     = sdata_q;
    assign rshift    = rshift_q;
    assign shift_clr = shift_clr_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/rxd_ctrl.md
RXD_CTRL -- requirements
Module: rxd_ctrl

Interface
REQ-001 Parameter BIT_CYCLES, default 16: clk cycles per received bit; legal values are 4 and above, even only.
REQ-002 Parameter HALF_CYCLES, default BIT_CYCLES/2: clk cycles from the start-bit falling edge to the start-bit midpoint sample.
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 serial_in  input  1  decoded IrDA receive line; idles high; asynchronous to clk.
REQ-006 sdata  output  1  synchronized receive bit; drives the shift register's serial input.
REQ-007 rshift  output  1  one-cycle shift strobe to the 10-bit right-shift register.
REQ-008 shift_clr  output  1  one-cycle synchronous clear to the shift register.
REQ-009 data_in  input  10  parallel contents of the shift register; bit 9 is the newest bit.
REQ-010 rx_data  output  8  received payload byte.
REQ-011 rx_valid  output  1  high while rx_data holds an unconsumed byte.
REQ-012 rx_ready  input  1  consumer accepts rx_data in any cycle where rx_valid=1 and rx_ready=1.
REQ-013 frame_err  output  1  one-cycle pulse on a bad frame.
REQ-014 overrun  output  1  sticky flag, set when a byte is lost; cleared only by reset.

Function
REQ-015 serial_in shall pass through a 2-flop synchronizer; sdata is the second flop; prev holds sdata delayed by one cycle.
REQ-016 The FSM shall have exactly these states: IDLE, START, SHIFT, CHECK.
REQ-017 IDLE: when sdata=0 and prev=1, go to START, clear the baud counter and bit counter, and pulse shift_clr in that same cycle.
REQ-018 START: the baud counter increments each cycle; when count = HALF_CYCLES-1:
- if sdata=0, pulse rshift, clear the baud counter, set the bit counter to 1, and go to SHIFT;
- otherwise (glitch) go to IDLE with no rshift.
REQ-019 SHIFT: the baud counter counts 0..BIT_CYCLES-1; at BIT_CYCLES-1, pulse rshift, increment the bit counter and wrap the baud counter to 0.
REQ-020 When the rshift pulse brings the bit counter to 10, the next state shall be CHECK; each frame produces exactly 10 rshift pulses.
REQ-021 CHECK lasts one cycle; frame_ok = (data_in[0]=0) and (data_in[9]=1).
REQ-022 CHECK with frame_ok=0: pulse frame_err; rx_data and rx_valid are unchanged; go to IDLE.
REQ-023 CHECK with frame_ok=1: load rx_data with data_in[8:1] (LSB first on the line), set rx_valid=1, go to IDLE.
REQ-024 If rx_valid=1 and rx_ready=0 in a CHECK cycle with frame_ok=1: the new byte overwrites rx_data and overrun is set.
REQ-025 If rx_valid=1 and rx_ready=1 in that same cycle: the new byte loads, rx_valid stays 1, and overrun is not set.
REQ-026 Outside that case, rx_valid=1 and rx_ready=1 shall clear rx_valid on the next edge; rx_ready while rx_valid=0 has no effect.
REQ-027 rshift and shift_clr shall never be high in the same cycle; both are registered outputs.
REQ-028 The baud counter width shall be clog2(BIT_CYCLES); the bit counter shall be 4 bits; neither counter shall wrap beyond its stated range.
REQ-029 A falling edge on sdata during SHIFT or CHECK shall be ignored; edge detection is active only in IDLE.
REQ-030 The earliest a new start edge can be accepted is the first IDLE cycle after CHECK.

Reset
REQ-031 While reset=0, the block shall enter IDLE asynchronously and hold the following values.
REQ-032 Held values: both counters 0, rshift=0, shift_clr=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, both synchronizer flops=1, prev=1.
REQ-033 Reset asserted mid-frame shall abandon the frame with no frame_err and no rx_valid.
REQ-034 After reset deasserts, the block shall need a fresh falling edge to start a frame.

Verification
REQ-035 Send byte 8'hA5 (start 0, LSB first, stop 1) at BIT_CYCLES=16 -> 10 rshift pulses, 16 cycles apart; rx_data=8'hA5; rx_valid=1; frame_err stays 0.
REQ-036 Drive a 5-cycle low glitch on the idle line -> no rshift pulses; FSM returns to IDLE; rx_valid stays 0.
REQ-037 Send 8'h3C with stop bit 0 -> one frame_err pulse; rx_valid stays 0; rx_data is unchanged.
REQ-038 Send 8'h11, then 8'h22 with rx_ready=0 throughout -> rx_data=8'h22 and overrun=1; a repeat with rx_ready=1 held in the CHECK cycle -> overrun stays 0.
REQ-039 Assert reset after the 5th rshift of a frame, release it, then send 8'h5A -> rx_data=8'h5A with no frame_err.
REQ-040 Send back-to-back frames 8'hFF then 8'h00 with a single idle bit between them -> both bytes are received in order with the rx_ready handshake.
